// File: rtl/rf_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : rf_write_arbiter_pkg
//  Brief   : Shared register-file constants and the saturating counter helper
//            used by the write-port arbiter.
//  Revision: 1.0 - initial release
// ============================================================================
package rf_write_arbiter_pkg;

  localparam int RF_AW = 5;
  localparam int RF_DW = 32;
  localparam logic [RF_AW-1:0] RF_ZERO_REG = 5'd0;

  // Width of each per-requester debug grant counter
  localparam int CNT_W = 8;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_write_arbiter_pick.sv
`default_nettype none
// ============================================================================
//  Module  : rr_pick
//  Brief   : Combinational round-robin picker. Searches the valid vector
//            starting one past the last granted index and returns the first
//            valid requester as a one-hot grant plus its binary index.
//  Revision: 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         i_valid,
  input  logic [$clog2(NREQ)-1:0] i_last_grant,
  output logic [NREQ-1:0]         o_grant,
  output logic [$clog2(NREQ)-1:0] o_idx
);

  localparam int c_LGW = $clog2(NREQ);

  int   w_pos;
  logic w_found;

  // Walk the requesters in priority order (last+1, last+2, ...) and stop at the first valid one
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_pos = int'(i_last_grant) + k;
      if (w_pos >= NREQ) w_pos = w_pos - NREQ;
      if (!w_found && i_valid[w_pos]) begin
        w_found        = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos[c_LGW-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : rf_write_arbiter
//  Brief   : Round-robin arbiter sharing the register file's single write port.
//            Registers the winning address/data/strobe toward the decoder and
//            array, suppresses writes to $zero, and offers a same-cycle bypass
//            compare for the read ports.
//  Revision: 1.0 - initial release
// ============================================================================
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [AW-1:0]     rf_c,
  output logic              rf_en,
  output logic [DW-1:0]     rf_pw,
  input  logic [AW-1:0]     byp_addr,
  output logic              byp_hit,
  output logic [DW-1:0]     byp_data,
  output logic [NREQ*8-1:0] grant_cnt
);

  localparam int               c_LGW       = $clog2(NREQ);
  localparam logic [c_LGW-1:0] c_LAST_INIT = c_LGW'(NREQ - 1);

  logic [c_LGW-1:0] r_last_grant;
  logic [NREQ-1:0]  w_grant;
  logic [c_LGW-1:0] w_idx;
  logic             w_xfer;
  logic [AW-1:0]    w_addr;
  logic [DW-1:0]    w_data;
  logic [AW-1:0]    r_c;
  logic [DW-1:0]    r_pw;
  logic             r_en;

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .i_valid      (req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_idx        (w_idx)
  );

  // The picker only grants valid requesters, so any grant bit is a transfer
  assign req_ready = w_grant;
  assign w_xfer    = |w_grant;

  // Select the winner's address and data from the one-hot grant
  always_comb begin
    w_addr = '0;
    w_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_addr = req_addr[i*AW +: AW];
        w_data = req_data[i*DW +: DW];
      end
    end
  end

  // Round-robin pointer advances only when a write is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= c_LAST_INIT;
    end else if (w_xfer) begin
      r_last_grant <= w_idx;
    end
  end

  // Output stage: writes to $zero are accepted but never strobe the array
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en <= 1'b0;
      r_c  <= '0;
      r_pw <= '0;
    end else if (w_xfer) begin
      if (w_addr == RF_ZERO_REG) begin
        r_en <= 1'b0;
        r_c  <= '0;
        r_pw <= '0;
      end else begin
        r_en <= 1'b1;
        r_c  <= w_addr;
        r_pw <= w_data;
      end
    end else begin
      r_en <= 1'b0;
    end
  end

  generate
    for (genvar g = 0; g < NREQ; g++) begin : g_cnt
      logic [CNT_W-1:0] r_cnt;

      // Saturating count of writes accepted from this requester
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_cnt <= '0;
        end else if (w_grant[g]) begin
          r_cnt <= sat_inc(r_cnt);
        end
      end

      assign grant_cnt[g*8 +: 8] = r_cnt;
    end
  endgenerate

  assign rf_en    = r_en;
  assign rf_c     = r_c;
  assign rf_pw    = r_pw;
  assign byp_hit  = r_en && (r_c == byp_addr);
  assign byp_data = byp_hit ? r_pw : '0;

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_rf_write_arbiter
//  Brief   : Self-checking bench for rf_write_arbiter (NREQ=2) with an
//            abstract reference model, directed cases and random traffic.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;

  localparam int N  = 2;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic [AW-1:0]   rf_c;
  logic            rf_en;
  logic [DW-1:0]   rf_pw;
  logic [AW-1:0]   byp_addr = '0;
  logic            byp_hit;
  logic [DW-1:0]   byp_data;
  logic [N*8-1:0]  grant_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  rf_write_arbiter #(.NREQ(N), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rf_c      (rf_c),
    .rf_en     (rf_en),
    .rf_pw     (rf_pw),
    .byp_addr  (byp_addr),
    .byp_hit   (byp_hit),
    .byp_data  (byp_data),
    .grant_cnt (grant_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  int            m_lg = N - 1;
  logic          m_en = 1'b0;
  logic [AW-1:0] m_c  = '0;
  logic [DW-1:0] m_pw = '0;
  int            m_cnt [N] = '{default: 0};

  function automatic int pick(input logic [N-1:0] v, input int lg);
    for (int k = 1; k <= N; k++) begin
      if (v[(lg + k) % N]) return (lg + k) % N;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one accepted write per edge, $zero discarded, counters saturate
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_lg  <= N - 1;
      m_en  <= 1'b0;
      m_c   <= '0;
      m_pw  <= '0;
      for (int i = 0; i < N; i++) m_cnt[i] <= 0;
    end else if (pick(req_valid, m_lg) >= 0) begin
      m_lg <= pick(req_valid, m_lg);
      m_cnt[pick(req_valid, m_lg)] <= (m_cnt[pick(req_valid, m_lg)] >= 255) ? 255
                                      : m_cnt[pick(req_valid, m_lg)] + 1;
      if (req_addr[pick(req_valid, m_lg)*AW +: AW] == '0) begin
        m_en <= 1'b0;
        m_c  <= '0;
        m_pw <= '0;
      end else begin
        m_en <= 1'b1;
        m_c  <= req_addr[pick(req_valid, m_lg)*AW +: AW];
        m_pw <= req_data[pick(req_valid, m_lg)*DW +: DW];
      end
    end else begin
      m_en <= 1'b0;
    end
  end

  // Compare every output against the model once per cycle
  always @(negedge clk) begin
    automatic int p = pick(req_valid, m_lg);
    automatic logic [N-1:0] exp_rdy = (p >= 0) ? N'(1 << p) : '0;
    automatic logic exp_hit = m_en && (m_c == byp_addr);
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    check("rf_en",     64'(rf_en),     64'(m_en));
    check("rf_c",      64'(rf_c),      64'(m_c));
    check("rf_pw",     64'(rf_pw),     64'(m_pw));
    check("byp_hit",   64'(byp_hit),   64'(exp_hit));
    check("byp_data",  64'(byp_data),  exp_hit ? 64'(m_pw) : 64'd0);
    for (int i = 0; i < N; i++)
      check("grant_cnt", 64'(grant_cnt[i*8 +: 8]), 64'(m_cnt[i]));
  end

  task automatic do_reset();
    @(posedge clk); #2;
    req_valid = '0;
    reset = 1'b1;
    @(negedge clk); #1;
    check("reset_rf_en", 64'(rf_en), 64'd0);
    check("reset_rf_c", 64'(rf_c), 64'd0);
    check("reset_cnt", 64'(grant_cnt), 64'd0);
    @(posedge clk); #2;
    reset = 1'b0;
  endtask

  initial begin
    logic [N-1:0] exp_seq [4];
    logic [AW-1:0] exp_c [4];
    exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_c   = '{5'd3, 5'd7, 5'd3, 5'd7};

    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // First write after reset goes to requester 0
    req_valid = 2'b01;
    req_addr[0 +: AW] = 5'd10;
    req_data[0 +: DW] = 32'hDEADBEEF;
    @(negedge clk); #1;
    check("t1_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #2;
    req_valid = '0;
    @(negedge clk); #1;
    check("t1_en", 64'(rf_en), 64'd1);
    check("t1_c", 64'(rf_c), 64'd10);
    check("t1_pw", 64'(rf_pw), 64'hDEADBEEF);
    check("t1_decE", 64'(32'h1 << rf_c), 64'h400);

    // Continuous contention alternates grants
    do_reset();
    req_valid = 2'b11;
    req_addr = {5'd7, 5'd3};
    req_data = {32'h7777, 32'h3333};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      check("t2_ready", 64'(req_ready), 64'(exp_seq[k]));
      if (k > 0) check("t2_c", 64'(rf_c), 64'(exp_c[k-1]));
      @(posedge clk); #2;
    end
    req_valid = '0;
    @(negedge clk); #1;
    check("t2_c_last", 64'(rf_c), 64'd7);
    check("t2_en_last", 64'(rf_en), 64'd1);

    // Write to $zero is handshaken but never strobes
    do_reset();
    req_valid = 2'b10;
    req_addr[AW +: AW] = 5'd0;
    req_data[DW +: DW] = 32'h1234;
    @(negedge clk); #1;
    check("t3_ready", 64'(req_ready), 64'd2);
    @(posedge clk); #2;
    req_valid = '0;
    @(negedge clk); #1;
    check("t3_en", 64'(rf_en), 64'd0);
    check("t3_cnt1", 64'(grant_cnt[15:8]), 64'd1);
    check("t3_pw", 64'(rf_pw), 64'd0);

    // Bypass hit and miss
    @(posedge clk); #2;
    req_valid = 2'b01;
    req_addr[0 +: AW] = 5'd25;
    req_data[0 +: DW] = 32'hA5A5A5A5;
    byp_addr = 5'd25;
    @(posedge clk); #2;
    req_valid = '0;
    @(negedge clk); #1;
    check("t4_hit", 64'(byp_hit), 64'd1);
    check("t4_data", 64'(byp_data), 64'hA5A5A5A5);
    byp_addr = 5'd24;
    #1;
    check("t4_miss", 64'(byp_hit), 64'd0);
    check("t4_miss_data", 64'(byp_data), 64'd0);

    // Reset in the middle of a committed write
    @(posedge clk); #2;
    req_valid = 2'b01;
    req_addr = {5'd12, 5'd9};
    req_data = {32'h12, 32'h55};
    @(posedge clk); #2;
    req_valid = 2'b11;
    check("t5_en_before", 64'(rf_en), 64'd1);
    reset = 1'b1;
    #1;
    check("t5_en_drop", 64'(rf_en), 64'd0);
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    check("t5_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #2;
    req_valid = '0;
    @(negedge clk); #1;
    check("t5_c", 64'(rf_c), 64'd9);

    // Random traffic against the model
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #2;
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_addr[i*AW +: AW] = ($urandom_range(0, 3) == 0) ? 5'd0 : AW'($urandom);
        req_data[i*DW +: DW] = $urandom;
      end
      byp_addr = $urandom_range(0, 1) ? m_c : AW'($urandom);
    end

    // Saturation of requester 0's counter
    do_reset();
    req_valid = 2'b01;
    req_addr[0 +: AW] = 5'd1;
    repeat (300) @(posedge clk);
    #2 req_valid = '0;
    @(negedge clk); #1;
    check("t6_cnt0", 64'(grant_cnt[7:0]), 64'd255);
    check("t6_cnt1", 64'(grant_cnt[15:8]), 64'd0);

    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the register file's single write port among `NREQ` write requesters, such as the pipeline WB stage and the multi-cycle multiply/divide return path. It arbitrates round-robin over valid/ready handshakes and drives the registered decoder-select, enable and data lines into `BinaryDecoder` and the register array. It also exposes a one-entry bypass lookup so that reads in the same cycle see the write currently being committed.

## Interface
- `NREQ`, default 2: number of write requesters, range 2..4.
- `AW`, default 5: register address width (32 registers).
- `DW`, default 32: data width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  requester i has a write pending.
- `req_addr`  in  NREQ*AW  destination register; slice i is `[i*AW +: AW]`.
- `req_data`  in  NREQ*DW  write data; slice i is `[i*DW +: DW]`.
- `req_ready`  out  NREQ  one-hot or zero; high means requester i's write is accepted this cycle.
- `rf_c`  out  AW  decoder select C.
- `rf_en`  out  1  decoder enable RF (write strobe).
- `rf_pw`  out  DW  register-file write data.
- `byp_addr`  in  AW  read-port address to check.
- `byp_hit`  out  1  `rf_en` is high and `rf_c == byp_addr`.
- `byp_data`  out  DW  equals `rf_pw` when `byp_hit`, else 0.
- `grant_cnt`  out  NREQ*8  per-requester saturating count of accepted writes (debug).

## Operation
- A transfer happens on requester i when `req_valid[i] & req_ready[i]`.
- Arbitration is combinational over the current `req_valid`:
  - Search starts at `(last_grant + 1) mod NREQ`.
  - The first valid requester found gets `req_ready`.
  - At most one `req_ready` bit is high.
- `last_grant` (`$clog2(NREQ)` bits) updates to the granted index only on a transfer. It holds when no request is valid.
- Output stage is registered. On a transfer at edge t, from t onward:
  - `rf_c` = winner's address
  - `rf_pw` = winner's data
  - `rf_en` = 1, unless the address is 0.
- Writes to register 0 (`$zero`):
  - Still handshaken (ready high, pointer advances, `grant_cnt` increments).
  - `rf_en` is 0, and `rf_c` and `rf_pw` load 0.
- No transfer in a cycle: `rf_en` = 0; `rf_c` and `rf_pw` hold their previous values.
- `grant_cnt[i]` increments on each transfer by i and saturates at 255.
- The arbiter never stalls: the register file accepts one write per cycle, so `req_ready` depends only on `req_valid` and `last_grant`.
- Requesters must hold `req_valid`, `req_addr` and `req_data` stable until they see `req_ready`. Dropping `req_valid` early is legal; the request simply withdraws.
- Two requesters targeting the same register are serialized in grant order; the later grant wins in the register file.

## Timing
- Latency from accept to `rf_en` high is one cycle.
- Throughput is one write per cycle.
- `req_ready` is combinational from `req_valid`. The requester side must not feed `req_ready` back into `req_valid` within the same cycle.
- `byp_hit` and `byp_data` are combinational from the registered output stage and `byp_addr`.
- Reset values (asynchronous, immediate):
  - `rf_en` = 0, `rf_c` = 0, `rf_pw` = 0
  - `last_grant` = NREQ-1, so requester 0 gets the first grant
  - all `grant_cnt` = 0
  - `req_ready` follows `req_valid` combinationally from those values
- Reset asserted mid-operation: the pending output-stage write is discarded and `rf_en` falls immediately. The first grant after deassertion goes to the lowest valid index.

## Structure
- Shared package/include: `RF_AW` = 5, `RF_DW` = 32, `RF_ZERO_REG` = 5'd0.
- One sub-module, `rr_pick`: combinational round-robin picker. Inputs are the valid vector and `last_grant`; outputs are the one-hot grant and the granted index.
- `rf_write_arbiter` holds the pointer, output registers, counters and bypass compare.
- The existing `BinaryDecoder` is instantiated by the integrating register-file top, not inside this block.

## Test plan
- After reset, `req_valid` = 2'b01 with addr 10, data 0xDEADBEEF → `req_ready` = 01. The next cycle shows `rf_en` = 1, `rf_c` = 10, `rf_pw` = 0xDEADBEEF, and decoder E = 0x00000400.
- Both requesters valid continuously (addr 3 and 7) → grants alternate 01, 10, 01, 10; `rf_c` sequence is 3, 7, 3, 7; one write per cycle.
- Requester 1 writes addr 0, data 0x1234 → `req_ready[1]` = 1, next-cycle `rf_en` = 0, `grant_cnt[1]` = 1.
- While `rf_en` = 1 with `rf_c` = 25 and `rf_pw` = 0xA5A5A5A5:
  - `byp_addr` = 25 → `byp_hit` = 1, `byp_data` = 0xA5A5A5A5.
  - `byp_addr` = 24 → `byp_hit` = 0, `byp_data` = 0.
- Assert reset for half a cycle while a write is in the output stage → `rf_en` drops before the next edge. After release with both valid, requester 0 is granted first.
- Requester 0 valid for 300 consecutive cycles → `grant_cnt[0]` saturates at 255 with no wrap.
